// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has absolute priority, and MDU results
// queue in a small FIFO that drains on idle cycles. Queued destinations drive decode hazard flags.
module rf_wb_arbiter #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pipe_valid,
  input  logic [4:0]  i_pipe_rd,
  input  logic [31:0] i_pipe_wd,
  input  logic        i_mdu_valid,
  output logic        o_mdu_ready,
  input  logic [4:0]  i_mdu_rd,
  input  logic [31:0] i_mdu_wd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  output logic        o_rs1_pend,
  output logic        o_rs2_pend,
  output logic        o_wb_stall,
  output logic        o_rf_we,
  output logic [4:0]  o_rf_ad,
  output logic [31:0] o_rf_wd
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [AW:0]   LP_FULL   = (AW + 1)'(DEPTH);
  localparam logic [SW-1:0] LP_STARVE = SW'(STARVE_MAX);

  logic [4:0]       r_rd_mem [DEPTH];
  logic [31:0]      r_wd_mem [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [SW-1:0]    r_starve;

  logic             w_empty;
  logic             w_full;
  logic             w_pipe_req;
  logic             w_fifo_req;
  logic             w_pop;
  logic             w_push;
  logic [DEPTH-1:0] w_vld_d;
  logic             w_rs1_hit;
  logic             w_rs2_hit;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == LP_FULL);
  assign w_pipe_req = i_pipe_valid && (i_pipe_rd != 5'd0);
  assign w_fifo_req = !w_empty;
  assign w_pop      = w_fifo_req && !w_pipe_req;
  // Handshakes with rd==0 complete but are not stored, so x0 is never written.
  assign w_push     = i_mdu_valid && o_mdu_ready && (i_mdu_rd != 5'd0);

  assign o_mdu_ready = !w_full && i_rst_n;
  assign o_wb_stall  = (r_starve == LP_STARVE) && i_rst_n;

  always_comb begin
    w_vld_d = r_vld;
    if (w_pop)  w_vld_d[r_rd_ptr] = 1'b0;
    if (w_push) w_vld_d[r_wr_ptr] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vld    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_starve <= '0;
    end else begin
      r_vld <= w_vld_d;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW + 1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (AW + 1)'(1);
      if (w_pop || w_empty)                                r_starve <= '0;
      else if (w_pipe_req && (r_starve != LP_STARVE))      r_starve <= r_starve + SW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_rd_mem[r_wr_ptr] <= i_mdu_rd;
      r_wd_mem[r_wr_ptr] <= i_mdu_wd;
    end
  end

  // The head being popped still flags: the regfile writes at negedge, after decode samples.
  always_comb begin
    w_rs1_hit = 1'b0;
    w_rs2_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (r_rd_mem[i] == i_rs1)) w_rs1_hit = 1'b1;
      if (r_vld[i] && (r_rd_mem[i] == i_rs2)) w_rs2_hit = 1'b1;
    end
  end

  assign o_rs1_pend = w_rs1_hit && (i_rs1 != 5'd0) && i_rst_n;
  assign o_rs2_pend = w_rs2_hit && (i_rs2 != 5'd0) && i_rst_n;

  always_comb begin
    o_rf_we = 1'b0;
    o_rf_ad = 5'd0;
    o_rf_wd = 32'd0;
    if (i_rst_n) begin
      if (w_pipe_req) begin
        o_rf_we = 1'b1;
        o_rf_ad = i_pipe_rd;
        o_rf_wd = i_pipe_wd;
      end else if (w_fifo_req) begin
        o_rf_we = 1'b1;
        o_rf_ad = r_rd_mem[r_rd_ptr];
        o_rf_wd = r_wd_mem[r_rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus random traffic, all outputs compared every
// cycle against a queue-based reference model.
module tb_rf_wb_arbiter;

  localparam int unsigned DEPTH      = 2;
  localparam int unsigned STARVE_MAX = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_wd;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_wd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_pend;
  logic        rs2_pend;
  logic        wb_stall;
  logic        rf_we;
  logic [4:0]  rf_ad;
  logic [31:0] rf_wd;

  int   n_checks = 0;
  int   n_errors = 0;
  ent_t q[$];
  int   starve = 0;

  rf_wb_arbiter #(
    .DEPTH      (DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_pipe_valid (pipe_valid),
    .i_pipe_rd    (pipe_rd),
    .i_pipe_wd    (pipe_wd),
    .i_mdu_valid  (mdu_valid),
    .o_mdu_ready  (mdu_ready),
    .i_mdu_rd     (mdu_rd),
    .i_mdu_wd     (mdu_wd),
    .i_rs1        (rs1),
    .i_rs2        (rs2),
    .o_rs1_pend   (rs1_pend),
    .o_rs2_pend   (rs2_pend),
    .o_wb_stall   (wb_stall),
    .o_rf_we      (rf_we),
    .o_rf_ad      (rf_ad),
    .o_rf_wd      (rf_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic pend(input logic [4:0] rs);
    pend = 1'b0;
    if (rs != 5'd0) foreach (q[i]) if (q[i].rd == rs) pend = 1'b1;
  endfunction

  // One clock cycle: drive, compare against the model, then advance the model across the edge.
  task automatic step(input logic rst, input logic pv, input logic [4:0] prd,
                      input logic [31:0] pwd, input logic mv, input logic [4:0] mrd,
                      input logic [31:0] mwd, input logic [4:0] r1, input logic [4:0] r2);
    logic        preq;
    logic        pop;
    logic        push;
    logic        e_we;
    logic [4:0]  e_ad;
    logic [31:0] e_wd;
    logic        e_stall;
    // A well-behaved hazard unit never drives pipe_valid while stalled.
    e_stall    = rst && (starve == STARVE_MAX);
    rst_n      = rst;
    pipe_valid = pv && !e_stall;
    pipe_rd    = prd;
    pipe_wd    = pwd;
    mdu_valid  = mv;
    mdu_rd     = mrd;
    mdu_wd     = mwd;
    rs1        = r1;
    rs2        = r2;
    #2;
    preq = pipe_valid && (prd != 5'd0);
    e_we = 1'b0;
    e_ad = 5'd0;
    e_wd = 32'd0;
    if (rst && preq) begin
      e_we = 1'b1; e_ad = prd; e_wd = pwd;
    end else if (rst && q.size() > 0) begin
      e_we = 1'b1; e_ad = q[0].rd; e_wd = q[0].wd;
    end
    check_eq("rf_we", rf_we, e_we);
    check_eq("rf_ad", rf_ad, e_ad);
    check_eq("rf_wd", rf_wd, e_wd);
    check_eq("mdu_ready", mdu_ready, rst && (q.size() < DEPTH));
    check_eq("wb_stall", wb_stall, e_stall);
    check_eq("rs1_pend", rs1_pend, rst && pend(r1));
    check_eq("rs2_pend", rs2_pend, rst && pend(r2));
    if (e_stall && pv) check_eq("proto_stall", pipe_valid, 1'b0);
    @(posedge clk);
    if (!rst) begin
      q.delete();
      starve = 0;
    end else begin
      pop  = !preq && (q.size() > 0);
      push = mv && (q.size() < DEPTH) && (mrd != 5'd0);
      if (pop || q.size() == 0)             starve = 0;
      else if (preq && starve < STARVE_MAX) starve++;
      if (pop)  void'(q.pop_front());
      if (push) q.push_back('{rd: mrd, wd: mwd});
    end
    #1;
  endtask

  task automatic idle(input logic [4:0] r1);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, 5'd0);
  endtask

  initial begin
    pipe_valid = 1'b0; pipe_rd = '0; pipe_wd = '0; mdu_valid = 1'b0;
    mdu_rd = '0; mdu_wd = '0; rs1 = '0; rs2 = '0; rst_n = 1'b0;
    repeat (2) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

    // Single MDU result drains on the next idle cycle.
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
    idle(5'd5);
    idle(5'd5);

    // Reset discards two queued entries.
    step(1'b1, 1'b1, 5'd3, 32'h11, 1'b1, 5'd9, 32'h99, 5'd9, 5'd0);
    step(1'b1, 1'b1, 5'd3, 32'h12, 1'b1, 5'd9, 32'h9A, 5'd9, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
    idle(5'd9);
    check_eq("rst_ready", mdu_ready, 1'b1);

    // Starvation: pipe busy with one queued entry.
    step(1'b1, 1'b1, 5'd3, 32'h21, 1'b1, 5'd4, 32'h44, 5'd4, 5'd0);
    repeat (4) step(1'b1, 1'b1, 5'd3, 32'h22, 1'b0, 5'd0, 32'd0, 5'd4, 5'd0);
    check_eq("stall_5th", wb_stall, 1'b1);
    repeat (3) step(1'b1, 1'b1, 5'd3, 32'h23, 1'b0, 5'd0, 32'd0, 5'd4, 5'd0);
    check_eq("stall_clr", wb_stall, 1'b0);

    // Full FIFO holds a third push until a pop frees a slot.
    step(1'b1, 1'b1, 5'd3, 32'h31, 1'b1, 5'd10, 32'hA0, 5'd10, 5'd11);
    step(1'b1, 1'b1, 5'd3, 32'h32, 1'b1, 5'd11, 32'hB0, 5'd10, 5'd11);
    step(1'b1, 1'b1, 5'd3, 32'h33, 1'b1, 5'd12, 32'hC0, 5'd12, 5'd11);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC0, 5'd12, 5'd11);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC0, 5'd12, 5'd11);
    repeat (3) idle(5'd12);

    // x0 writes from either source are never issued.
    step(1'b1, 1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66, 5'd0, 5'd0);
    idle(5'd0);
    check_eq("x0_we", rf_we, 1'b0);

    // Two writes to x7 retire in order.
    step(1'b1, 1'b1, 5'd3, 32'h41, 1'b1, 5'd7, 32'hAAAA, 5'd7, 5'd0);
    step(1'b1, 1'b1, 5'd3, 32'h42, 1'b1, 5'd7, 32'hBBBB, 5'd7, 5'd0);
    repeat (3) idle(5'd7);

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)),
           $urandom, ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
